// File: rtl/serial_subtractor4bit_pkg.sv
`default_nettype none
// ============================================================================
// serial_subtractor4bit_pkg : shared state encoding and helpers for the
//                             bit-serial subtract path.
// Revision 1.0
// ============================================================================
package serial_subtractor4bit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Counter must reach WIDTH-1; one spare bit keeps the compare simple.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor4bit_full_subtractor.sv
`default_nettype none
// ============================================================================
// full_subtractor : 1-bit combinational subtract cell, diff = x - y - bin.
// Revision 1.0
// ============================================================================
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor4bit.sv
`default_nettype none
// ============================================================================
// serial_subtractor4bit : d = a - b - b_input, one bit per clock, LSB first,
//                         with start/busy/done handshake.
// Revision 1.0
// ============================================================================
module serial_subtractor4bit
    import serial_subtractor4bit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_input,
    output logic [WIDTH-1:0] d,
    output logic             b_output,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             w_diff;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_shift;

    full_subtractor u_cell (
        .x    (a_sh_q[0]),
        .y    (b_sh_q[0]),
        .bin  (br_q),
        .diff (w_diff),
        .bout (w_bout)
    );

    // Each new difference bit enters at the MSB so bit 0 lands in place last.
    assign w_res_shift = {w_diff, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = b_input;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = w_bout;
                res_d  = w_res_shift;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    d_d     = w_res_shift;
                    bout_d  = w_bout;
                    ovf_d   = (a_msb_q != b_msb_q) && (w_res_shift[WIDTH-1] != a_msb_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign d        = d_q;
    assign b_output = bout_q;
    assign overflow = ovf_q;
    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor4bit.sv
`default_nettype none
// ============================================================================
// tb_serial_subtractor4bit : directed and random stimulus against an
//                            arithmetic reference model.
// Revision 1.0
// ============================================================================
module tb_serial_subtractor4bit;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_input;
    logic [WIDTH-1:0] d;
    logic             b_output;
    logic             overflow;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    serial_subtractor4bit #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .b_input  (b_input),
        .d        (d),
        .b_output (b_output),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference: result computed with plain arithmetic on acceptance, then
    // revealed after WIDTH busy cycles.
    int remaining = 0;
    int pend_d = 0;
    bit pend_bo = 0, pend_ov = 0;
    int exp_d = 0;
    bit exp_bo = 0, exp_ov = 0, exp_busy = 0, exp_done = 0;

    always @(posedge clk) begin
        if (rst) begin
            remaining = 0;
            exp_d = 0; exp_bo = 0; exp_ov = 0; exp_busy = 0; exp_done = 0;
        end else if (exp_done) begin
            exp_done = 0;
        end else if (remaining > 0) begin
            remaining = remaining - 1;
            if (remaining == 0) begin
                exp_busy = 0;
                exp_done = 1;
                exp_d = pend_d; exp_bo = pend_bo; exp_ov = pend_ov;
            end
        end else if (start) begin
            int ai, bi, sa, sb, sd;
            ai = int'(a); bi = int'(b);
            pend_d  = (ai - bi - int'(b_input)) & MASK;
            pend_bo = (ai < bi + int'(b_input));
            sa = (ai >> (WIDTH - 1)) & 1;
            sb = (bi >> (WIDTH - 1)) & 1;
            sd = (pend_d >> (WIDTH - 1)) & 1;
            pend_ov = (sa != sb) && (sd != sa);
            remaining = WIDTH;
            exp_busy = 1;
        end
    end

    always @(negedge clk) begin
        checks = checks + 1;
        if (d !== exp_d[WIDTH-1:0] || b_output !== exp_bo || overflow !== exp_ov ||
            busy !== exp_busy || done !== exp_done) begin
            errors = errors + 1;
            $display("FAIL cycle_cmp t=%0t actual d=%b bo=%b ov=%b busy=%b done=%b required d=%b bo=%b ov=%b busy=%b done=%b",
                     $time, d, b_output, overflow, busy, done,
                     exp_d[WIDTH-1:0], exp_bo, exp_ov, exp_busy, exp_done);
        end
    end

    task automatic wait_done(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout actual done never seen required done pulse", name);
        end
    endtask

    task automatic check_lit(input string name, input logic [WIDTH-1:0] ed,
                             input logic ebo, input logic eov);
        checks = checks + 1;
        if (d !== ed || b_output !== ebo || overflow !== eov) begin
            errors = errors + 1;
            $display("FAIL %s actual d=%b bo=%b ov=%b required d=%b bo=%b ov=%b",
                     name, d, b_output, overflow, ed, ebo, eov);
        end
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] ia,
                          input logic [WIDTH-1:0] ib, input logic ibin,
                          input logic [WIDTH-1:0] ed, input logic ebo, input logic eov);
        bit ok;
        int lat;
        @(negedge clk);
        a = ia; b = ib; b_input = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        ok = 0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            if (done === 1'b1) begin ok = 1; break; end
            @(negedge clk);
            lat++;
        end
        checks = checks + 1;
        if (!ok || lat != WIDTH + 1) begin
            errors = errors + 1;
            $display("FAIL %s_latency actual %0d cycles required %0d", name, lat, WIDTH + 1);
        end
        check_lit(name, ed, ebo, eov);
    endtask

    initial begin
        bit ok;
        int dones;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; b_input = 1'b0;
        repeat (2) @(negedge clk);
        check_lit("reset", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run_op("op_1011_0100", 4'b1011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b1);
        run_op("op_0111_1101_b1", 4'b0111, 4'b1101, 1'b1, 4'b1001, 1'b1, 1'b1);
        run_op("op_0000_0000_b1", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
        run_op("op_1000_0001", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
        run_op("op_0101_0101", 4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        check_lit("hold_in_idle", 4'b0000, 1'b0, 1'b0);

        // Second request during SHIFT and DONE must be dropped.
        a = 4'b1011; b = 4'b0100; b_input = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 4'b1111; b = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", ok);
        start = 1'b1;
        dones = 0;
        if (ok) check_lit("ignore_result", 4'b0111, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks = checks + 1;
        if (dones != 0 || d !== 4'b0111) begin
            errors = errors + 1;
            $display("FAIL ignore_no_requeue actual extra_dones=%0d d=%b required 0 and 0111", dones, d);
        end

        // Abort mid-SHIFT.
        a = 4'b1111; b = 4'b0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_lit("abort_clear", 4'b0000, 1'b0, 1'b0);
        checks = checks + 1;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL abort_flags actual busy=%b done=%b required 0 0", busy, done);
        end
        repeat (WIDTH + 2) @(negedge clk);
        run_op("after_abort", 4'b0110, 4'b0011, 1'b0, 4'b0011, 1'b0, 1'b0);

        // Random traffic, including start during busy and occasional resets.
        for (int i = 0; i < 600; i++) begin
            a       = WIDTH'($urandom);
            b       = WIDTH'($urandom);
            b_input = 1'($urandom);
            start   = ($urandom_range(0, 2) != 0);
            rst     = ($urandom_range(0, 79) == 0);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0;
        repeat (2 * WIDTH) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
